// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, widths and bit-timing helper for the UART echo stage
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  // Clocks per serial bit, integer-truncated
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous count-based byte FIFO with same-cycle push/pop at full
module uart_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DW-1:0]          din,
  input  logic                   pop,
  output logic [DW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still honoured
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo.sv
// rtl/uart_echo.sv - 8N1 receiver, byte queue and transmitter forming a buffered echo
module uart_echo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        uart_rx,
  input  logic                        tx_en,
  output logic                        uart_tx,
  output logic                        rx_err,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(CPB);
  localparam int BW  = $clog2(UART_DW);
  localparam logic [CW-1:0] LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DW - 1);

  logic [1:0]         rx_sync;
  logic               rx_s;
  logic               rx_prev;
  rx_state_t          rx_state, rx_state_n;
  logic [CW-1:0]      rx_cnt, rx_cnt_n;
  logic [BW-1:0]      rx_bit, rx_bit_n;
  logic [UART_DW-1:0] rx_shift, rx_shift_n;
  logic               rx_push, rx_push_n;
  logic               rx_err_n;

  tx_state_t          tx_state, tx_state_n;
  logic [CW-1:0]      tx_cnt, tx_cnt_n;
  logic [BW-1:0]      tx_bit, tx_bit_n;
  logic [UART_DW-1:0] tx_shift, tx_shift_n;
  logic               tx_line;
  logic               tx_last;
  logic               tx_pop;

  logic [UART_DW-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;

  assign rx_s = rx_sync[1];

  // Two-flop synchroniser plus previous value for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], uart_rx};
      rx_prev <= rx_sync[1];
    end
  end

  // RX state register; push request and error pulse are registered at the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_push  <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_push  <= rx_push_n;
      rx_err   <= rx_err_n;
    end
  end

  // RX next state: mid-start check, eight mid-bit samples, then stop decision
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + 1'b1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push_n  = 1'b0;
    rx_err_n   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s, rx_shift[UART_DW-1:1]};
          rx_bit_n   = rx_bit + 1'b1;
          if (rx_bit == LAST_BIT) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_push_n  = rx_s;
          rx_err_n   = !rx_s;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Overflow is judged on the write cycle so a coincident TX pop makes room
  assign ovf = rx_push && fifo_full && !tx_pop;

  uart_fifo #(
    .DW    (UART_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (tx_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .cnt   (fifo_cnt)
  );

  assign tx_last = (tx_cnt == LAST);
  // Pop from idle, or at the end of a stop bit so frames run back-to-back
  assign tx_pop  = tx_en && !fifo_empty &&
                   ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && tx_last));

  // TX state register; the line itself is a register so it resets high asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line;
    end
  end

  // TX next state: each of start, eight data and stop bits lasts one bit period
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line    = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (tx_pop) begin
          tx_state_n = TX_START;
          tx_shift_n = fifo_dout;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_last) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_last) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          tx_bit_n   = tx_bit + 1'b1;
          if (tx_bit == LAST_BIT) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_last) begin
          tx_cnt_n = '0;
          if (tx_pop) begin
            tx_state_n = TX_START;
            tx_shift_n = fifo_dout;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

endmodule

// File: doc/uart_echo.md
# uart_echo

Buffered UART echo stage for the board self-test top. It sits between the `uart_rx` and `uart_tx` board pins, in place of the bare wire loopback. Received 8N1 bytes are deserialised, checked for framing, queued in a small FIFO and re-serialised. The bench can then see framing errors, overflow and exact byte integrity instead of a wire.

## Interface
Parameters:
- `CLK_FREQ`, default 27_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `FIFO_DEPTH`, default 16: byte queue depth. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `tx_en`  in  1  TX may start a new frame when 1. A frame already in progress always completes.
- `uart_tx`  out  1  serial output, idle high. Reset value 1.
- `rx_err`  out  1  one-cycle pulse: stop bit sampled 0, byte dropped. Reset value 0.
- `ovf`  out  1  one-cycle pulse: byte received while FIFO full, byte dropped. Reset value 0.
- `fifo_cnt`  out  $clog2(FIFO_DEPTH)+1  bytes queued. Reset value 0.

## Operation
- `CLKS_PER_BIT = CLK_FREQ / BAUD`, integer-truncated. Default value is 234. Bit counters are sized from it.
- `uart_rx` passes through a 2-flop synchroniser; both flops reset to 1. All RX logic uses the synchronised value.
- RX FSM has states IDLE, START, DATA, STOP.
  - IDLE→START on a synchronised 1→0 edge.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 0, go to DATA. If 1, the edge was a glitch; return to IDLE, no pulse.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 samples.
  - STOP: one sample after CLKS_PER_BIT more cycles.
    - Sample 1 and FIFO not full: push the byte.
    - Sample 1 and FIFO full: pulse `ovf`.
    - Sample 0: pulse `rx_err`.
    - In every case return to IDLE on that same cycle, i.e. at mid-stop-bit.
- FIFO is synchronous, registered write, count-based full/empty.
  - Push and pop in the same cycle are both honoured and the count is unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM has states IDLE, START, DATA, STOP.
  - IDLE→START when FIFO not empty and `tx_en`=1. The pop happens on that cycle and the byte is latched into the shift register.
  - Each state holds for exactly CLKS_PER_BIT cycles.
  - Bit order: start=0, 8 data bits LSB first, stop=1.
  - STOP→IDLE. If data is pending and `tx_en`=1, START follows on the next cycle, so frames are back-to-back with no extra idle bit.
- `tx_en` falling mid-frame does not truncate the frame.
- `uart_tx` is driven from a register. It is never combinational from state.

## Timing
- The stop-sample cycle is edge S.
- FIFO write and `fifo_cnt` increment are visible after edge S+1.
- With TX idle and `tx_en`=1, the pop occurs at edge S+2 and `uart_tx` falls at edge S+3.
- Echo latency is fixed at 3 clocks after the stop sample.
- TX frame length is exactly 10·CLKS_PER_BIT cycles.
- `rx_err` and `ovf` are asserted for exactly the one cycle after edge S.
- Asserting `rst_n` at any point behaves identically:
  - `uart_tx`=1 immediately, without waiting for a clock.
  - Both FSMs go to IDLE, FIFO empties, pulses clear.
  - The partial byte is discarded.
  - After release, the first RX frame requires a fresh falling edge.

## Structure
- Package `uart_pkg`:
  - `rx_state_t` and `tx_state_t` enums.
  - `clks_per_bit(clk_freq, baud)` function.
  - Data width constant `UART_DW = 8`.
- Sub-module `uart_fifo`: synchronous FIFO with parameters DW and DEPTH, ports `push`, `din`, `pop`, `dout`, `full`, `empty`, `cnt`. `dout` is valid while not empty.
- RX and TX FSMs live inline in `uart_echo`.

## Test plan
All scenarios run with CLK_FREQ=1_000_000, BAUD=100_000, giving 10 clocks/bit.
- **Single echo.** Send 0xA5 with `tx_en`=1. Required: identical 0xA5 frame on `uart_tx`, falling 3 clocks after the RX stop sample, 100 clocks long, no pulses.
- **Framing error.** Send 0x3C with stop bit held 0. Required: `rx_err` high for 1 cycle, `fifo_cnt` stays 0, `uart_tx` stays 1.
- **Glitch reject.** Drive `uart_rx` low for 3 clocks, then high. Required: no frame, no pulses, `fifo_cnt`=0.
- **Overflow.** With `tx_en`=0, send bytes 0x00..0x10 (17 bytes). Required: `fifo_cnt`=16 and one `ovf` pulse on the 17th byte. Then set `tx_en`=1. Required: 16 frames 0x00..0x0F, back-to-back, then `fifo_cnt`=0.
- **Reset mid-frame.** Pull `rst_n` low during TX bit 4 of 0x5A. Required: `uart_tx`=1 without waiting for a clock edge. After release: `fifo_cnt`=0 and no further TX activity.
- **Simultaneous push/pop at full.** FIFO full, `tx_en` raised so that its pop lands on an RX push cycle. Required: `fifo_cnt` stays 16, no `ovf`, byte order preserved.
